// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap/mret sequencer for the RV32 EXE stage.
// Optional build macro: CSR_VECTORED_EN (vectored interrupt dispatch via mtvec[0]).
module csr_unit #(
    parameter logic [31:0] HART_ID   = 32'd0,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
    parameter bit          CNT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic [2:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wsrc,
    input  logic        csr_src_zero,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        exe_valid,
    input  logic [31:0] exe_pc,
    input  logic [31:0] exe_inst,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_soft,
    output logic        trap_valid,
    output logic [31:0] trap_pc,
    output logic        mret_valid,
    output logic [31:0] mret_pc
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

`ifdef CSR_VECTORED_EN
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
`else
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]  mie_q, mie_d;            // {MEIE, MTIE, MSIE}
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic        csr_known;
    logic [31:0] csr_old;
    logic [31:0] csr_new;
    logic        write_intent;
    logic        read_only;
    logic        wr_commit;

    logic        pend_e, pend_t, pend_s;
    logic        irq_take;
    logic [3:0]  irq_code;
    logic        exc_ill, exc_brk, exc_ecall;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        vec_mode;
    logic [31:0] vec_off;

    logic        cyc_wr_lo, cyc_wr_hi, ret_wr_lo, ret_wr_hi;
    logic        retire;

    logic        unused_op_bit;
    assign unused_op_bit = csr_op[2];

    // Read mux: pre-write value, combinational.
    always_comb begin
        csr_known = 1'b1;
        csr_old   = 32'd0;
        case (csr_addr)
            A_MSTATUS:   csr_old = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            A_MISA:      csr_old = MISA_VAL;
            A_MIE:       csr_old = {20'd0, mie_q[2], 3'd0, mie_q[1], 3'd0, mie_q[0], 3'd0};
            A_MTVEC:     csr_old = mtvec_q;
            A_MSCRATCH:  csr_old = mscratch_q;
            A_MEPC:      csr_old = mepc_q;
            A_MCAUSE:    csr_old = mcause_q;
            A_MTVAL:     csr_old = mtval_q;
            A_MIP:       csr_old = {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_soft, 3'd0};
            A_MCYCLE:    csr_old = mcycle_q[31:0];
            A_MCYCLEH:   csr_old = mcycle_q[63:32];
            A_MINSTRET:  csr_old = minstret_q[31:0];
            A_MINSTRETH: csr_old = minstret_q[63:32];
            A_MVENDORID: csr_old = 32'd0;
            A_MARCHID:   csr_old = 32'd0;
            A_MIMPID:    csr_old = 32'd0;
            A_MHARTID:   csr_old = HART_ID;
            default:     csr_known = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op[1:0])
            2'b01:   csr_new = csr_wsrc;
            2'b10:   csr_new = csr_old | csr_wsrc;
            2'b11:   csr_new = csr_old & ~csr_wsrc;
            default: csr_new = csr_old;
        endcase
    end

    // RW always writes; set/clear with a zero source is a pure read.
    assign write_intent = (csr_op[1:0] == 2'b01) ||
                          ((csr_op[1:0] != 2'b00) && !csr_src_zero);
    assign read_only    = (csr_addr[11:10] == 2'b11);
    assign csr_illegal  = csr_en && (!csr_known || (read_only && write_intent));
    assign csr_rdata    = csr_old;

    assign pend_e   = mie_q[2] && irq_ext;
    assign pend_t   = mie_q[1] && irq_timer;
    assign pend_s   = mie_q[0] && irq_soft;
    assign irq_take = exe_valid && mstatus_mie_q && (pend_e || pend_t || pend_s);
    assign irq_code = pend_e ? 4'd11 : (pend_s ? 4'd3 : 4'd7);

    assign exc_ill   = exe_valid && csr_illegal;
    assign exc_brk   = exe_valid && ebreak;
    assign exc_ecall = exe_valid && ecall;

    assign trap_valid = !rst && (irq_take || exc_ill || exc_brk || exc_ecall);
    assign mret_valid = !rst && exe_valid && mret && !trap_valid;
    assign mret_pc    = mepc_q;

    always_comb begin
        if (irq_take) begin
            trap_cause = {1'b1, 27'd0, irq_code};
            trap_tval  = 32'd0;
        end else if (exc_ill) begin
            trap_cause = 32'd2;
            trap_tval  = exe_inst;
        end else if (exc_brk) begin
            trap_cause = 32'd3;
            trap_tval  = exe_pc;
        end else begin
            trap_cause = 32'd11;
            trap_tval  = 32'd0;
        end
    end

`ifdef CSR_VECTORED_EN
    assign vec_mode = mtvec_q[0];
`else
    assign vec_mode = 1'b0;
`endif
    assign vec_off = (vec_mode && irq_take) ? {26'd0, irq_code, 2'b00} : 32'd0;
    assign trap_pc = {mtvec_q[31:2], 2'b00} + vec_off;

    assign wr_commit = csr_en && exe_valid && !csr_illegal && !trap_valid && write_intent;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (trap_valid) begin
            mepc_d         = {exe_pc[31:2], 2'b00};
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_valid) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_commit) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mstatus_mie_d  = csr_new[3];
                    mstatus_mpie_d = csr_new[7];
                end
                A_MIE:      mie_d      = {csr_new[11], csr_new[7], csr_new[3]};
                A_MTVEC:    mtvec_d    = csr_new & MTVEC_MASK;
                A_MSCRATCH: mscratch_d = csr_new;
                A_MEPC:     mepc_d     = {csr_new[31:2], 2'b00};
                A_MCAUSE:   mcause_d   = csr_new;
                A_MTVAL:    mtval_d    = csr_new;
                default:    ;
            endcase
        end
    end

    assign cyc_wr_lo = wr_commit && (csr_addr == A_MCYCLE);
    assign cyc_wr_hi = wr_commit && (csr_addr == A_MCYCLEH);
    assign ret_wr_lo = wr_commit && (csr_addr == A_MINSTRET);
    assign ret_wr_hi = wr_commit && (csr_addr == A_MINSTRETH);
    assign retire    = exe_valid && !trap_valid;

    // A write to either half freezes the whole 64-bit counter for that cycle.
    always_comb begin
        mcycle_d   = 64'd0;
        minstret_d = 64'd0;
        if (CNT_EN) begin
            if (cyc_wr_lo || cyc_wr_hi) begin
                mcycle_d = {cyc_wr_hi ? csr_new : mcycle_q[63:32],
                            cyc_wr_lo ? csr_new : mcycle_q[31:0]};
            end else begin
                mcycle_d = mcycle_q + 64'd1;
            end
            if (ret_wr_lo || ret_wr_hi) begin
                minstret_d = {ret_wr_hi ? csr_new : minstret_q[63:32],
                              ret_wr_lo ? csr_new : minstret_q[31:0]};
            end else if (retire) begin
                minstret_d = minstret_q + 64'd1;
            end else begin
                minstret_d = minstret_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 3'd0;
            mtvec_q        <= MTVEC_RST & MTVEC_MASK;
            mscratch_q     <= 32'd0;
            mepc_q         <= 32'd0;
            mcause_q       <= 32'd0;
            mtval_q        <= 32'd0;
            mcycle_q       <= 64'd0;
            minstret_q     <= 64'd0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: CSR ops, traps, interrupts, mret, counters.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_en;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wsrc;
    logic        csr_src_zero;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        exe_valid;
    logic [31:0] exe_pc;
    logic [31:0] exe_inst;
    logic        ecall, ebreak, mret;
    logic        irq_ext, irq_timer, irq_soft;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        mret_valid;
    logic [31:0] mret_pc;

    int checks = 0;
    int failures = 0;

`ifdef CSR_VECTORED_EN
    localparam logic [31:0] EXP_MTVEC  = 32'h8000_0101;
    localparam logic [31:0] EXP_PC_MEI = 32'h0000_022C;
    localparam logic [31:0] EXP_PC_MSI = 32'h0000_020C;
`else
    localparam logic [31:0] EXP_MTVEC  = 32'h8000_0100;
    localparam logic [31:0] EXP_PC_MEI = 32'h0000_0200;
    localparam logic [31:0] EXP_PC_MSI = 32'h0000_0200;
`endif

    always #5 clk = ~clk;

    csr_unit dut (
        .clk(clk), .rst(rst),
        .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wsrc(csr_wsrc),
        .csr_src_zero(csr_src_zero), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_inst(exe_inst),
        .ecall(ecall), .ebreak(ebreak), .mret(mret),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .mret_valid(mret_valid), .mret_pc(mret_pc)
    );

    task automatic idle();
        csr_en = 1'b0; csr_op = 3'b000; csr_addr = 12'h000; csr_wsrc = 32'd0;
        csr_src_zero = 1'b0; exe_valid = 1'b0; exe_pc = 32'd0; exe_inst = 32'h0000_0013;
        ecall = 1'b0; ebreak = 1'b0; mret = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Side-effect-free read: set-bits with a zero source and no retiring instruction.
    task automatic peek(input logic [11:0] a, output logic [31:0] d);
        csr_en = 1'b1; csr_op = 3'b010; csr_addr = a; csr_wsrc = 32'd0;
        csr_src_zero = 1'b1; exe_valid = 1'b0;
        #1;
        d = csr_rdata;
        csr_en = 1'b0;
    endtask

    task automatic csr_ins(input logic [2:0] op, input logic [11:0] a,
                           input logic [31:0] src, input logic zero);
        idle();
        csr_en = 1'b1; csr_op = op; csr_addr = a; csr_wsrc = src;
        csr_src_zero = zero; exe_valid = 1'b1; exe_pc = 32'h0000_1000;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
        idle();
        tick();
        exe_valid = 1'b1; ecall = 1'b1; mret = 1'b1;
        #1;
        checks++; if (trap_valid !== 1'b0 || mret_valid !== 1'b0) begin failures++;
            $display("FAIL reset_redirect: trap=%b mret=%b want 0 0", trap_valid, mret_valid); end
        tick();
        rst = 1'b0;
        idle();
        peek(12'h300, d);
        checks++; if (d !== 32'h0000_1800) begin failures++; $display("FAIL reset_mstatus: got %h want %h", d, 32'h0000_1800); end
        peek(12'h305, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_mtvec: got %h want 0", d); end
        peek(12'h301, d);
        checks++; if (d !== 32'h4000_0100) begin failures++; $display("FAIL reset_misa: got %h want 40000100", d); end
        peek(12'h340, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_mscratch: got %h want 0", d); end
        $display("reset: done");
    endtask

    task automatic test_mtvec();
        logic [31:0] d;
        csr_ins(3'b001, 12'h305, 32'h8000_0103, 1'b0);
        checks++; if (csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin failures++;
            $display("FAIL mtvec_old: got %h ill=%b want 0 0", csr_rdata, csr_illegal); end
        tick(); idle();
        peek(12'h305, d);
        checks++; if (d !== EXP_MTVEC) begin failures++; $display("FAIL mtvec_rb: got %h want %h", d, EXP_MTVEC); end
        $display("csrrw mtvec 80000103 -> %h", d);
    endtask

    task automatic test_set_clear();
        logic [31:0] d;
        csr_ins(3'b001, 12'h340, 32'h0F, 1'b0); tick();
        csr_ins(3'b010, 12'h340, 32'hF0, 1'b0);
        checks++; if (csr_rdata !== 32'h0F) begin failures++; $display("FAIL rs_old: got %h want 0000000f", csr_rdata); end
        tick(); idle();
        peek(12'h340, d);
        checks++; if (d !== 32'hFF) begin failures++; $display("FAIL rs_new: got %h want 000000ff", d); end
        csr_ins(3'b011, 12'h340, 32'h0F, 1'b0);
        checks++; if (csr_rdata !== 32'hFF) begin failures++; $display("FAIL rc_old: got %h want 000000ff", csr_rdata); end
        tick(); idle();
        peek(12'h340, d);
        checks++; if (d !== 32'hF0) begin failures++; $display("FAIL rc_new: got %h want 000000f0", d); end
        csr_ins(3'b010, 12'h340, 32'hFFFF, 1'b1); tick(); idle();
        peek(12'h340, d);
        checks++; if (d !== 32'hF0) begin failures++; $display("FAIL rs_zero_nowrite: got %h want 000000f0", d); end
        $display("mscratch set/clear: final %h", d);
    endtask

    task automatic test_ecall_mret();
        logic [31:0] d;
        csr_ins(3'b001, 12'h305, 32'h200, 1'b0); tick();
        csr_ins(3'b010, 12'h300, 32'h8, 1'b0);
        checks++; if (csr_rdata !== 32'h1800) begin failures++; $display("FAIL mstatus_old: got %h want 00001800", csr_rdata); end
        tick();
        idle(); exe_valid = 1'b1; ecall = 1'b1; exe_pc = 32'h100;
        #1;
        checks++; if (trap_valid !== 1'b1 || trap_pc !== 32'h200) begin failures++;
            $display("FAIL ecall_trap: valid=%b pc=%h want 1 00000200", trap_valid, trap_pc); end
        tick(); idle();
        peek(12'h341, d);
        checks++; if (d !== 32'h100) begin failures++; $display("FAIL ecall_mepc: got %h want 00000100", d); end
        peek(12'h342, d);
        checks++; if (d !== 32'd11) begin failures++; $display("FAIL ecall_mcause: got %h want 0000000b", d); end
        peek(12'h300, d);
        checks++; if (d !== 32'h1880) begin failures++; $display("FAIL ecall_mstatus: got %h want 00001880", d); end
        idle(); exe_valid = 1'b1; mret = 1'b1;
        #1;
        checks++; if (mret_valid !== 1'b1 || mret_pc !== 32'h100 || trap_valid !== 1'b0) begin failures++;
            $display("FAIL mret: valid=%b pc=%h trap=%b want 1 00000100 0", mret_valid, mret_pc, trap_valid); end
        tick(); idle();
        peek(12'h300, d);
        checks++; if (d !== 32'h1888) begin failures++; $display("FAIL mret_mstatus: got %h want 00001888", d); end
        $display("ecall@100 -> trap, mret -> %h", mret_pc);
    endtask

    task automatic test_irq();
        logic [31:0] d;
        csr_ins(3'b001, 12'h304, 32'h888, 1'b0); tick();
        csr_ins(3'b001, 12'h305, 32'h201, 1'b0); tick();
        idle(); irq_ext = 1'b1; irq_timer = 1'b1;
        #1;
        checks++; if (trap_valid !== 1'b0) begin failures++; $display("FAIL irq_no_valid: trap=%b want 0", trap_valid); end
        peek(12'h344, d);
        checks++; if (d !== 32'h880) begin failures++; $display("FAIL mip: got %h want 00000880", d); end
        idle(); exe_valid = 1'b1; exe_pc = 32'h300;
        #1;
        checks++; if (trap_valid !== 1'b1 || trap_pc !== EXP_PC_MEI) begin failures++;
            $display("FAIL mei_trap: valid=%b pc=%h want 1 %h", trap_valid, trap_pc, EXP_PC_MEI); end
        tick(); idle();
        peek(12'h342, d);
        checks++; if (d !== 32'h8000_000B) begin failures++; $display("FAIL mei_cause: got %h want 8000000b", d); end
        peek(12'h341, d);
        checks++; if (d !== 32'h300) begin failures++; $display("FAIL mei_mepc: got %h want 00000300", d); end
        irq_ext = 1'b0; irq_soft = 1'b1;
        idle(); exe_valid = 1'b1;
        #1;
        checks++; if (trap_valid !== 1'b0) begin failures++; $display("FAIL irq_masked: trap=%b want 0", trap_valid); end
        tick();
        csr_ins(3'b010, 12'h300, 32'h8, 1'b0); tick();
        idle(); exe_valid = 1'b1; mret = 1'b1; exe_pc = 32'h500;
        #1;
        checks++; if (trap_valid !== 1'b1 || mret_valid !== 1'b0 || trap_pc !== EXP_PC_MSI) begin failures++;
            $display("FAIL msi_over_mret: trap=%b mret=%b pc=%h want 1 0 %h", trap_valid, mret_valid, trap_pc, EXP_PC_MSI); end
        tick(); idle();
        peek(12'h342, d);
        checks++; if (d !== 32'h8000_0003) begin failures++; $display("FAIL msi_cause: got %h want 80000003", d); end
        irq_timer = 1'b0; irq_soft = 1'b0;
        $display("irq: MEI then MSI taken, last cause %h", d);
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        csr_ins(3'b001, 12'hF14, 32'h55, 1'b0);
        exe_pc = 32'h400; exe_inst = 32'hF142_9073;
        #1;
        checks++; if (csr_illegal !== 1'b1 || trap_valid !== 1'b1 || trap_pc !== 32'h200) begin failures++;
            $display("FAIL ill_trap: ill=%b trap=%b pc=%h want 1 1 00000200", csr_illegal, trap_valid, trap_pc); end
        tick(); idle();
        peek(12'h342, d);
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL ill_cause: got %h want 00000002", d); end
        peek(12'h343, d);
        checks++; if (d !== 32'hF142_9073) begin failures++; $display("FAIL ill_mtval: got %h want f1429073", d); end
        csr_ins(3'b010, 12'hF14, 32'h0, 1'b1);
        checks++; if (csr_rdata !== 32'd0 || csr_illegal !== 1'b0 || trap_valid !== 1'b0) begin failures++;
            $display("FAIL hartid_read: data=%h ill=%b trap=%b want 0 0 0", csr_rdata, csr_illegal, trap_valid); end
        tick();
        csr_ins(3'b010, 12'h7C0, 32'h0, 1'b1);
        checks++; if (csr_illegal !== 1'b1) begin failures++; $display("FAIL unknown_addr: ill=%b want 1", csr_illegal); end
        tick();
        idle(); exe_valid = 1'b1; ebreak = 1'b1; ecall = 1'b1; exe_pc = 32'h600;
        #1;
        tick(); idle();
        peek(12'h342, d);
        checks++; if (d !== 32'd3) begin failures++; $display("FAIL ebreak_cause: got %h want 00000003", d); end
        peek(12'h343, d);
        checks++; if (d !== 32'h600) begin failures++; $display("FAIL ebreak_mtval: got %h want 00000600", d); end
        $display("illegal/ebreak: last mtval %h", d);
    endtask

    task automatic test_counters();
        logic [31:0] d;
        csr_ins(3'b001, 12'hB00, 32'hFFFF_FFFF, 1'b0); tick();
        csr_ins(3'b001, 12'hB80, 32'h0, 1'b0); tick();
        idle();
        peek(12'hB00, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mcycle_held: got %h want ffffffff", d); end
        peek(12'hB80, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL mcycleh_wr: got %h want 0", d); end
        tick(); idle();
        peek(12'hB80, d);
        checks++; if (d !== 32'h1) begin failures++; $display("FAIL mcycleh_carry: got %h want 00000001", d); end
        peek(12'hB00, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL mcycle_wrap: got %h want 0", d); end
        csr_ins(3'b001, 12'hB02, 32'h10, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            idle(); exe_valid = 1'b1; tick();
        end
        idle();
        peek(12'hB02, d);
        checks++; if (d !== 32'h15) begin failures++; $display("FAIL minstret_5: got %h want 00000015", d); end
        tick(); tick();
        idle(); exe_valid = 1'b1; ecall = 1'b1; tick(); idle();
        peek(12'hB02, d);
        checks++; if (d !== 32'h15) begin failures++; $display("FAIL minstret_hold: got %h want 00000015", d); end
        $display("counters: minstret %h", d);
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        idle(); exe_valid = 1'b1; ecall = 1'b1; exe_pc = 32'h700; rst = 1'b1;
        #1;
        checks++; if (trap_valid !== 1'b0) begin failures++; $display("FAIL abort_trap: trap=%b want 0", trap_valid); end
        tick(); rst = 1'b0; idle();
        peek(12'h341, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL abort_mepc: got %h want 0", d); end
        peek(12'hB00, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL abort_mcycle: got %h want 0", d); end
        $display("reset abort: mepc %h", 32'h0);
    endtask

    initial begin
        test_reset();
        test_mtvec();
        test_set_clear();
        test_ecall_mret();
        test_irq();
        test_illegal();
        test_counters();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
